// File: rtl/switch_debounce_if.sv
// rtl/switch_debounce_if.sv - raw switch inputs and conditioned level/pulse outputs of switch_debounce
interface switch_debounce_if;
   logic sw1_raw;
   logic sw2_raw;
   logic x1;
   logic x2;
   logic x1_chg;
   logic x2_chg;
   logic any_chg;

   modport master (
      output sw1_raw, sw2_raw,
      input  x1, x2, x1_chg, x2_chg, any_chg
   );

   modport slave (
      input  sw1_raw, sw2_raw,
      output x1, x2, x1_chg, x2_chg, any_chg
   );
endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - two-channel switch debouncer with change pulses
// Define SWITCH_DEBOUNCE_SYNC_EN to put a two-flop synchroniser in front of each channel.
module switch_debounce #(
   parameter int   DEBOUNCE_CYCLES = 16,
   parameter logic INIT_LEVEL      = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   switch_debounce_if.slave   bus
);
   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STABLE = 1'b0, COUNT = 1'b1} state_t;

   logic [1:0]    raw;
   logic [1:0]    s;
   state_t        state_q [2];
   state_t        state_d [2];
   logic [CW-1:0] cnt_q   [2];
   logic [CW-1:0] cnt_d   [2];
   logic [1:0]    x_q;
   logic [1:0]    x_d;
   logic [1:0]    chg_q;
   logic [1:0]    chg_d;
   logic          any_q;

   assign raw = {bus.sw2_raw, bus.sw1_raw};

`ifdef SWITCH_DEBOUNCE_SYNC_EN
   logic [1:0] sync1_q;
   logic [1:0] sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= {2{INIT_LEVEL}};
         sync2_q <= {2{INIT_LEVEL}};
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = raw;
`endif

   // A single differing sample at DEBOUNCE_CYCLES==1 flips straight from STABLE.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         x_d[i]     = x_q[i];
         chg_d[i]   = 1'b0;
         case (state_q[i])
            STABLE: begin
               cnt_d[i] = '0;
               if (s[i] != x_q[i]) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     x_d[i]   = s[i];
                     chg_d[i] = 1'b1;
                  end else begin
                     cnt_d[i]   = CW'(1);
                     state_d[i] = COUNT;
                  end
               end
            end
            COUNT: begin
               if (s[i] == x_q[i]) begin
                  cnt_d[i]   = '0;
                  state_d[i] = STABLE;
               end else if (cnt_q[i] == CNT_LAST) begin
                  x_d[i]     = s[i];
                  chg_d[i]   = 1'b1;
                  cnt_d[i]   = '0;
                  state_d[i] = STABLE;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            default: begin
               cnt_d[i]   = '0;
               state_d[i] = STABLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= STABLE;
            cnt_q[i]   <= '0;
         end
         x_q   <= {2{INIT_LEVEL}};
         chg_q <= 2'b00;
         any_q <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         x_q   <= x_d;
         chg_q <= chg_d;
         any_q <= |chg_d;
      end
   end

   assign bus.x1      = x_q[0];
   assign bus.x2      = x_q[1];
   assign bus.x1_chg  = chg_q[0];
   assign bus.x2_chg  = chg_q[1];
   assign bus.any_chg = any_q;
endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - scoreboard bench for switch_debounce at DEBOUNCE_CYCLES 4 and 1
module tb_switch_debounce;
`ifdef SWITCH_DEBOUNCE_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif
   localparam int LAT_A = 4 + SYNC_LAT;
   localparam int LAT_B = 1 + SYNC_LAT;

   typedef struct {
      int   ch;
      int   at;
      logic lvl;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   exp_t exp_q[$];
   logic exp_lvl [4];
   logic ev      [4];
   logic obs_chg [4];
   logic obs_x   [4];

   switch_debounce_if a_if ();
   switch_debounce_if b_if ();

   switch_debounce #(.DEBOUNCE_CYCLES(4), .INIT_LEVEL(1'b0)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (a_if)
   );

   switch_debounce #(.DEBOUNCE_CYCLES(1), .INIT_LEVEL(1'b0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp = n_cmp + 1;
      if (obs != exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int ch, input int at, input logic lvl);
      exp_t e;
      e.ch  = ch;
      e.at  = at;
      e.lvl = lvl;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Channels 0/1 are dut_a x1/x2, channels 2/3 are dut_b x1/x2.
   always @(negedge clk) begin
      obs_chg = '{a_if.x1_chg, a_if.x2_chg, b_if.x1_chg, b_if.x2_chg};
      obs_x   = '{a_if.x1, a_if.x2, b_if.x1, b_if.x2};
      for (int ch = 0; ch < 4; ch++) begin
         ev[ch] = 1'b0;
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].ch == ch && exp_q[i].at == cyc) begin
               ev[ch]      = 1'b1;
               exp_lvl[ch] = exp_q[i].lvl;
               exp_q.delete(i);
            end
         end
         if (!rst_n) exp_lvl[ch] = 1'b0;
         check($sformatf("chg%0d", ch), int'(obs_chg[ch]), int'(ev[ch]));
         check($sformatf("x%0d", ch), int'(obs_x[ch]), int'(exp_lvl[ch]));
      end
      check("any_a", int'(a_if.any_chg), int'(ev[0] | ev[1]));
      check("any_b", int'(b_if.any_chg), int'(ev[2] | ev[3]));
   end

   initial begin
      logic v1;
      logic v2;
      cyc   = 0;
      n_cmp = 0;
      n_bad = 0;
      for (int ch = 0; ch < 4; ch++) exp_lvl[ch] = 1'b0;
      rst_n = 1'b0;
      a_if.sw1_raw = 1'b1;
      a_if.sw2_raw = 1'b1;
      b_if.sw1_raw = 1'b0;
      b_if.sw2_raw = 1'b0;

      // Reset held with inputs high, then release.
      step(5);
      rst_n = 1'b1;
      push(0, cyc + LAT_A, 1'b1);
      push(1, cyc + LAT_A, 1'b1);
      step(LAT_A + 3);

      // Both fall together.
      a_if.sw1_raw = 1'b0;
      a_if.sw2_raw = 1'b0;
      push(0, cyc + LAT_A, 1'b0);
      push(1, cyc + LAT_A, 1'b0);
      step(LAT_A + 3);

      // Bounce on sw1, then settle high.
      for (int k = 0; k < 10; k++) begin
         a_if.sw1_raw = ~a_if.sw1_raw;
         step(2);
      end
      a_if.sw1_raw = 1'b1;
      push(0, cyc + LAT_A, 1'b1);
      step(LAT_A + 3);

      // Glitch of 3 cycles on sw2.
      a_if.sw2_raw = 1'b1;
      step(3);
      a_if.sw2_raw = 1'b0;
      step(LAT_A + 3);
      check("glitch_x2", int'(a_if.x2), 0);

      // Simultaneous rise from 00.
      a_if.sw1_raw = 1'b0;
      push(0, cyc + LAT_A, 1'b0);
      step(LAT_A + 3);
      a_if.sw1_raw = 1'b1;
      a_if.sw2_raw = 1'b1;
      push(0, cyc + LAT_A, 1'b1);
      push(1, cyc + LAT_A, 1'b1);
      step(LAT_A + 3);
      check("sim_xor", int'(a_if.x1 ^ a_if.x2), 0);

      // Mid-count asynchronous reset with x2 high.
      a_if.sw1_raw = 1'b0;
      push(0, cyc + LAT_A, 1'b0);
      step(LAT_A + 3);
      a_if.sw1_raw = 1'b1;
      step(3);
      rst_n = 1'b0;
      #1;
      check("arst_x1", int'(a_if.x1), 0);
      check("arst_x2", int'(a_if.x2), 0);
      check("arst_chg", int'({a_if.x1_chg, a_if.x2_chg, a_if.any_chg}), 0);
      step(2);
      rst_n = 1'b1;
      push(0, cyc + LAT_A, 1'b1);
      push(1, cyc + LAT_A, 1'b1);
      step(LAT_A + 3);

      // Single-cycle filter: every raw change on dut_b must follow.
      for (int k = 0; k < 24; k++) begin
         v1 = 1'($urandom_range(0, 1));
         v2 = (k % 3 == 0) ? ~b_if.sw2_raw : b_if.sw2_raw;
         if (v1 != b_if.sw1_raw) push(2, cyc + LAT_B, v1);
         if (v2 != b_if.sw2_raw) push(3, cyc + LAT_B, v2);
         b_if.sw1_raw = v1;
         b_if.sw2_raw = v2;
         step(1);
      end
      step(LAT_B + 3);

      check("pending", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
